// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encodings, status bit
// positions, CPU register addresses and the 2-of-3 vote helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int STAT_FULL = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_FERR = 2;

  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_DATA   = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both flops reset
// to 1 so an idle-high line and an inactive low-true strobe read as idle.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a one-byte holding register and a CPU
// read port. Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  inout  wire  [7:0] DATA,
  input  logic       R,
  input  logic       ADDR,
  input  logic       RXD
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] TICK_MID = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] TICK_END = CW'(OVS - 1);

  logic w_rxd;
  logic w_r;

  uart_sync2 u_sync_rxd (.i_clk(CLK), .i_rst_n(RESET_N), .i_d(RXD), .o_q(w_rxd));
  uart_sync2 u_sync_r   (.i_clk(CLK), .i_rst_n(RESET_N), .i_d(R),   .o_q(w_r));

  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_hold;
  logic          r_full;
  logic          r_ovr;
  logic          r_ferr;
  logic          r_rxd_p1;
  logic          r_r_d;
  logic          r_armed;
  logic [1:0]    r_settle;

  logic       w_sample;
  logic       w_store;
  logic       w_stop_bad;
  logic       w_rd_clr;
  logic [7:0] w_status;

  // One extra line stage so the synchronizer output is the look-ahead (S+1) tap.
`ifdef UART_RX_MAJORITY_EN
  logic r_rxd_p2;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_rxd_p2 <= 1'b1;
    else          r_rxd_p2 <= r_rxd_p1;
  end

  assign w_sample = maj3(r_rxd_p2, r_rxd_p1, w_rxd);
`else
  assign w_sample = r_rxd_p1;
`endif

  assign w_store    = (r_state == ST_STOP) && (r_cnt == TICK_END);
  assign w_stop_bad = ~w_sample;
  assign w_rd_clr   = w_r & ~r_r_d & (ADDR == ADDR_DATA);

  always_comb begin
    w_status            = 8'h00;
    w_status[STAT_FULL] = r_full;
    w_status[STAT_OVR]  = r_ovr;
    w_status[STAT_FERR] = r_ferr;
  end

  assign DATA = !R ? ((ADDR == ADDR_DATA) ? r_hold : w_status) : 8'bz;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_shift  <= 8'h00;
      r_hold   <= 8'h00;
      r_full   <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
      r_rxd_p1 <= 1'b1;
      r_r_d    <= 1'b1;
      r_armed  <= 1'b0;
      r_settle <= 2'd0;
    end else begin
      r_rxd_p1 <= w_rxd;
      r_r_d    <= w_r;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;

      case (r_state)
        ST_IDLE: begin
          // Arm only on a genuine high line, never on synchronizer reset values.
          if (r_settle == 2'd3 && r_rxd_p1) r_armed <= 1'b1;
          if (r_armed && !r_rxd_p1) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == TICK_MID) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_state <= w_sample ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == TICK_END) begin
            r_cnt   <= '0;
            r_shift <= {w_sample, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == TICK_END) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (w_stop_bad) r_armed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A data read landing on the store cycle frees the register for the new byte.
      if (w_store) begin
        if (!r_full || w_rd_clr) begin
          r_hold <= r_shift;
          r_full <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
        if (w_rd_clr) begin
          r_ovr  <= 1'b0;
          r_ferr <= w_stop_bad;
        end else if (w_stop_bad) begin
          r_ferr <= 1'b1;
        end
      end else if (w_rd_clr) begin
        r_full <= 1'b0;
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter OVS, default 16, meaning CLK cycles per bit period (even, 4..64).
REQ-003 Port CLK  input  1  oversampling clock, all state on rising edge.
REQ-004 Port RESET_N  input  1  asynchronous active-low reset.
REQ-005 Port DATA  inout  8  CPU data bus, driven only during a read, else high-Z.
REQ-006 Port R  input  1  active-low read strobe, asynchronous to CLK.
REQ-007 Port ADDR  input  1  register select: 0 = status, 1 = receive data.
REQ-008 Port RXD  input  1  serial line, idle high, asynchronous to CLK.

Function
REQ-009 RXD and R SHALL each pass through a 2-flop synchronizer before use, adding 2 CLK latency.
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 States SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on synchronized RXD = 0; the tick counter clears.
REQ-013 START: at tick OVS/2-1, RXD = 1 -> IDLE (false start, nothing stored); RXD = 0 -> DATA, counter clears.
REQ-014 DATA: each bit SHALL be sampled at tick OVS-1 and shifted in at bit 7 (LSB first); the 3-bit index wraps 7 -> 0 -> STOP.
REQ-015 STOP: at tick OVS-1, sample RXD; a 0 sets FERR; the shift byte is stored in all cases; next state IDLE.
REQ-016 Store: if FULL = 0, copy the shift byte to the holding register and set FULL on the next CLK edge; if FULL = 1, discard the byte and set OVR.
REQ-017 Status byte SHALL be {5'b0, FERR, OVR, FULL} (bits 2,1,0).
REQ-018 DATA SHALL be driven combinationally while R = 0: ADDR = 0 gives status, ADDR = 1 gives the holding register.
REQ-019 A data read completes on the synchronized rising edge of R with ADDR = 1; that edge SHALL clear FULL, OVR and FERR.
REQ-020 ADDR SHALL be stable from R falling until 3 CLK after R rising; behaviour is otherwise undefined.
REQ-021 Store and read-clear in the same cycle: the new byte SHALL be loaded, FULL stays 1, OVR is not set, and FERR takes the new frame's value.
REQ-022 Status reads SHALL have no side effects.
REQ-023 A break (RXD held low) SHALL produce byte 0x00 with FERR set, then stay in IDLE until RXD returns high before detecting the next start.

Reset
REQ-024 RESET_N low SHALL force IDLE, counter 0, shift and holding registers 0x00, FULL/OVR/FERR 0, and synchronizer flops 1.
REQ-025 Reset mid-frame SHALL abort the frame without storing; after release, a start is detected only on a fresh low RXD.

Configuration
REQ-026 With macro UART_RX_MAJORITY_EN defined, each start, data and stop sample SHALL be the 2-of-3 majority of RXD at ticks S-1, S and S+1 around the nominal sample tick S.
REQ-027 With UART_RX_MAJORITY_EN undefined, each sample SHALL be the single value at tick S; timing and state sequence are otherwise identical.

Structure
REQ-028 Package uart_pkg SHALL hold the state encodings, the status bit positions (FULL = 0, OVR = 1, FERR = 2) and the register addresses.
REQ-029 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) SHALL be instantiated for RXD and for R.

Verification
REQ-030 Frame 0x55 at OVS = 16 -> status reads 0x01, data reads 0x55, then status reads 0x00.
REQ-031 RXD low for 4 CLK, then high -> state returns to IDLE, status stays 0x00.
REQ-032 Frame 0xA3 with stop bit 0 -> status 0x05, data 0xA3, status 0x00 after the data read.
REQ-033 Frames 0x11 then 0x22 with no read -> status 0x03, data 0x11, status 0x00 after the read.
REQ-034 RESET_N pulsed low during bit 4 of a frame -> status 0x00; the next clean frame 0x7E is received correctly.
REQ-035 With UART_RX_MAJORITY_EN defined, a 1-CLK inverted glitch on the sample tick of every bit of 0xC3 -> data reads 0xC3; without the macro -> data reads 0x3C and status shows FERR.
